// File: rtl/sobel_window_fetch.sv
// Scans a stored frame in raster order and emits one 3x3 neighbourhood per interior pixel.
// Latency: first window 11 cycles after start, then 5 cycles per in-row step, 11 per new row.
// Backpressure: while win_valid & !win_ready the window holds and no RAM reads are issued.
module sobel_window_fetch #(
    parameter int AW    = 12,
    parameter int DW    = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     ram_addr_read,
    output logic              ram_rw,
    input  logic [DW-1:0]     ram_data_out,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [9*DW-1:0]   win_data,
    output logic [AW-1:0]     win_row,
    output logic [AW-1:0]     win_col
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STEP,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 2);
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 2);

    state_t            state_q;
    logic [AW-1:0]     row_q, col_q;
    logic [1:0]        rd_r_q, rd_c_q;
    logic [AW-1:0]     addr_q;
    logic              cap_vld_q;
    logic [3:0]        cap_slot_q;
    logic [9*DW-1:0]   win_q;
    logic              win_vld_q, busy_q, done_q, rw_q;

    logic [1:0]        fill_r_d, fill_c_d;
    logic [AW-1:0]     fill_addr_d, step_addr_d;
    logic [3:0]        rd_slot_d;

    // Linear frame address, truncated to the RAM address width.
    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] r, input logic [AW-1:0] c);
        logic [31:0] a;
        a = 32'(r) * 32'(IMG_W) + 32'(c);
        return a[AW-1:0];
    endfunction

    // Next read position within the 3x3 block, and the window slot the current read lands in.
    always_comb begin
        fill_c_d    = (rd_c_q == 2'd2) ? 2'd0 : rd_c_q + 2'd1;
        fill_r_d    = (rd_c_q == 2'd2) ? rd_r_q + 2'd1 : rd_r_q;
        fill_addr_d = pix_addr(row_q - AW'(1) + AW'(fill_r_d), col_q - AW'(1) + AW'(fill_c_d));
        step_addr_d = pix_addr(row_q + AW'(rd_r_q), col_q + AW'(1));
        rd_slot_d   = 4'(rd_r_q) * 4'd3 + 4'(rd_c_q);
    end

    // Scan FSM: issues reads, tracks the centre, captures returning pixels one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            rd_r_q     <= '0;
            rd_c_q     <= '0;
            addr_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_slot_q <= '0;
            win_q      <= '0;
            win_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        row_q   <= AW'(1);
                        col_q   <= AW'(1);
                        rd_r_q  <= 2'd0;
                        rd_c_q  <= 2'd0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        rw_q    <= 1'b1;
                    end
                end
                S_FILL: begin
                    cap_vld_q  <= 1'b1;
                    cap_slot_q <= rd_slot_d;
                    if (rd_r_q == 2'd2 && rd_c_q == 2'd2) begin
                        state_q <= S_WAIT;
                    end else begin
                        rd_r_q <= fill_r_d;
                        rd_c_q <= fill_c_d;
                        addr_q <= fill_addr_d;
                    end
                end
                S_STEP: begin
                    cap_vld_q  <= 1'b1;
                    cap_slot_q <= rd_slot_d;
                    if (rd_r_q == 2'd2) begin
                        state_q <= S_WAIT;
                    end else begin
                        rd_r_q <= rd_r_q + 2'd1;
                        addr_q <= step_addr_d;
                    end
                end
                S_WAIT: begin
                    cap_vld_q <= 1'b0;
                    win_vld_q <= 1'b1;
                    state_q   <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (win_ready) begin
                        win_vld_q <= 1'b0;
                        if (col_q == LAST_COL) begin
                            if (row_q == LAST_ROW) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                rw_q    <= 1'b0;
                            end else begin
                                state_q <= S_FILL;
                                row_q   <= row_q + AW'(1);
                                col_q   <= AW'(1);
                                rd_r_q  <= 2'd0;
                                rd_c_q  <= 2'd0;
                                addr_q  <= pix_addr(row_q, '0);
                            end
                        end else begin
                            // Slide left by one column; the new right column is refetched.
                            state_q <= S_STEP;
                            col_q   <= col_q + AW'(1);
                            rd_r_q  <= 2'd0;
                            rd_c_q  <= 2'd2;
                            addr_q  <= pix_addr(row_q - AW'(1), col_q + AW'(2));
                            for (int r = 0; r < 3; r++) begin
                                win_q[DW*(3*r)   +: DW] <= win_q[DW*(3*r+1) +: DW];
                                win_q[DW*(3*r+1) +: DW] <= win_q[DW*(3*r+2) +: DW];
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (cap_vld_q) begin
                win_q[DW*int'(cap_slot_q) +: DW] <= ram_data_out;
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram_addr_read = addr_q;
    assign ram_rw        = rw_q;
    assign win_valid     = win_vld_q;
    assign win_data      = win_q;
    assign win_row       = row_q;
    assign win_col       = col_q;

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Bench for sobel_window_fetch on an 8x8 frame whose RAM holds pixel value = address.
// Expected window centres are queued at start and matched against each accepted window.
// Timing, backpressure, row wrap, mid-frame reset and start-while-busy are checked per task.
module tb_sobel_window_fetch;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, ram_rw, win_valid;
    logic              win_ready = 1'b0;
    logic [AW-1:0]     ram_addr_read, win_row, win_col;
    logic [DW-1:0]     ram_data_out = '0;
    logic [9*DW-1:0]   win_data;

    sobel_window_fetch #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr_read(ram_addr_read), .ram_rw(ram_rw), .ram_data_out(ram_data_out),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_row(win_row), .win_col(win_col)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    always @(posedge clk) ram_data_out <= mem[ram_addr_read];

    typedef struct { int r; int c; } win_t;
    win_t exp_q[$];

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0;
    int win_cnt = 0, done_cnt = 0, done_cyc = 0;
    int rise_cyc [64];
    int hs_cyc   [64];
    bit prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[DW*(3*rr+cc) +: DW] = 8'((r - 1 + rr) * W + (c - 1 + cc));
        return w;
    endfunction

    // Scoreboard consumer: every accepted window must be the next expected centre.
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid && !prev_valid && win_cnt < 64) rise_cyc[win_cnt] = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (win_valid && win_ready) begin
                win_t e;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: window (%0d,%0d) accepted, none expected", win_row, win_col);
                end else begin
                    e = exp_q.pop_front();
                    if (win_row !== AW'(e.r) || win_col !== AW'(e.c) || win_data !== exp_win(e.r, e.c)) begin
                        bad++;
                        $display("FAIL sb_window: got (%0d,%0d) %h, want (%0d,%0d) %h",
                                 win_row, win_col, win_data, e.r, e.c, exp_win(e.r, e.c));
                    end
                end
                if (win_cnt < 64) hs_cyc[win_cnt] = cyc;
                win_cnt++;
            end
        end
        prev_valid = win_valid;
    end

    task automatic start_frame();
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++) exp_q.push_back('{r, c});
        win_cnt  = 0;
        done_cnt = 0;
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, win_valid, ram_rw} !== 4'b0 || ram_addr_read !== '0 ||
            win_data !== '0 || win_row !== '0 || win_col !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b rw=%b addr=%0d row=%0d col=%0d, want all 0",
                     busy, done, win_valid, ram_rw, ram_addr_read, win_row, win_col);
        end
        @(posedge clk) #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, win_valid, ram_rw} !== 3'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b valid=%b rw=%b, want 0", busy, win_valid, ram_rw);
        end
    endtask

    task automatic test_first_window();
        win_ready = 1'b1;
        start_frame();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 9) begin
                int ea;
                ea = ((k - 1) / 3) * W + (k - 1) % 3;
                total++;
                if (ram_addr_read !== AW'(ea) || busy !== 1'b1 || ram_rw !== 1'b1) begin
                    bad++;
                    $display("FAIL fill_read cycle %0d: addr=%0d busy=%b rw=%b, want addr=%0d busy=1 rw=1",
                             k, ram_addr_read, busy, ram_rw, ea);
                end
            end
            total++;
            if (win_valid !== 1'b0) begin
                bad++;
                $display("FAIL early_valid cycle %0d: valid=%b, want 0", k, win_valid);
            end
        end
        @(negedge clk);
        total++;
        if (win_valid !== 1'b1 || win_row !== 6'd1 || win_col !== 6'd1 || win_data !== exp_win(1, 1)) begin
            bad++;
            $display("FAIL first_window cycle 11: valid=%b (%0d,%0d) %h, want valid=1 (1,1) %h",
                     win_valid, win_row, win_col, win_data, exp_win(1, 1));
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        wait_done(2000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL frame_timeout: done=%0d pulses, want 1 within 2000 cycles", done_cnt);
        end
        repeat (10) @(negedge clk);
        total++;
        if (win_cnt != 36 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL frame_count: windows=%0d done=%0d left=%0d, want 36 1 0", win_cnt, done_cnt, exp_q.size());
        end
        total++;
        if (rise_cyc[1] - hs_cyc[0] != 5) begin
            bad++;
            $display("FAIL step_latency: %0d cycles, want 5", rise_cyc[1] - hs_cyc[0]);
        end
        total++;
        if (done_cyc - hs_cyc[35] != 1) begin
            bad++;
            $display("FAIL done_timing: done %0d cycles after last handshake, want 1", done_cyc - hs_cyc[35]);
        end
        total++;
        if (busy !== 1'b0 || ram_rw !== 1'b0 || win_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_frame: busy=%b rw=%b valid=%b, want 0", busy, ram_rw, win_valid);
        end
    endtask

    task automatic test_row_wrap();
        total++;
        if (rise_cyc[0] - t0 + 1 != 11) begin
            bad++;
            $display("FAIL start_latency: first valid in cycle %0d, want 11", rise_cyc[0] - t0 + 1);
        end
        total++;
        if (rise_cyc[6] - hs_cyc[5] != 11) begin
            bad++;
            $display("FAIL row_wrap_latency: %0d cycles, want 11", rise_cyc[6] - hs_cyc[5]);
        end
    endtask

    task automatic test_backpressure();
        bit ok, check_next;
        check_next = 1'b0;
        win_ready  = 1'b0;
        start_frame();
        for (int n = 0; n < 36; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (win_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL bp_timeout: window %0d never valid, want valid within 50 cycles", n);
                break;
            end
            if (check_next) begin
                check_next = 1'b0;
                total++;
                if (win_row !== 6'd2 || win_col !== 6'd4) begin
                    bad++;
                    $display("FAIL bp_next: got (%0d,%0d), want (2,4)", win_row, win_col);
                end
            end
            if (win_row == 6'd2 && win_col == 6'd3) begin
                logic [9*DW-1:0] sd;
                logic [AW-1:0] sa;
                sd = win_data;
                sa = ram_addr_read;
                for (int s = 0; s < 20; s++) begin
                    @(negedge clk);
                    total++;
                    if (win_valid !== 1'b1 || win_data !== sd || win_row !== 6'd2 ||
                        win_col !== 6'd3 || ram_addr_read !== sa) begin
                        bad++;
                        $display("FAIL bp_hold %0d: valid=%b (%0d,%0d) addr=%0d, want 1 (2,3) addr=%0d",
                                 s, win_valid, win_row, win_col, ram_addr_read, sa);
                    end
                end
                check_next = 1'b1;
            end
            @(posedge clk) #1 win_ready = 1'b1;
            @(posedge clk) #1 win_ready = 1'b0;
        end
        wait_done(100, ok);
        total++;
        if (!ok || win_cnt != 36 || done_cnt != 1) begin
            bad++;
            $display("FAIL bp_frame: windows=%0d done=%0d, want 36 1", win_cnt, done_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int dc;
        win_ready = 1'b1;
        start_frame();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (win_valid && win_row == 6'd3 && win_col == 6'd3) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_find: window (3,3) not seen, want seen within 1000 cycles");
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, win_valid, ram_rw} !== 4'b0 || ram_addr_read !== '0 ||
            win_data !== '0 || win_row !== '0 || win_col !== '0) begin
            bad++;
            $display("FAIL rst_async: busy=%b done=%b valid=%b rw=%b addr=%0d row=%0d col=%0d, want all 0",
                     busy, done, win_valid, ram_rw, ram_addr_read, win_row, win_col);
        end
        dc = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt != dc || busy !== 1'b0 || win_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_done: done pulses=%0d busy=%b valid=%b, want %0d 0 0", done_cnt, busy, win_valid, dc);
        end
        exp_q.delete();
        start_frame();
        wait_done(2000, ok);
        repeat (3) @(negedge clk);
        total++;
        if (!ok || win_cnt != 36 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_rescan: windows=%0d done=%0d left=%0d, want 36 1 0", win_cnt, done_cnt, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_start_while_busy();
        bit ok;
        win_ready = 1'b1;
        start_frame();
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (90) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        wait_done(2000, ok);
        repeat (40) @(negedge clk);
        total++;
        if (!ok || win_cnt != 36 || done_cnt != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL busy_start: windows=%0d done=%0d busy=%b left=%0d, want 36 1 0 0",
                     win_cnt, done_cnt, busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_full_frame();
        test_row_wrap();
        test_backpressure();
        test_reset_midframe();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
